// File: rtl/bit_reversal_sched_if.sv
// Request/response handshake bundle for the
// shared bit-reversal network scheduler.
interface bit_reversal_sched_if #(
  parameter int SIZE  = 256,
  parameter int WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [SIZE*WIDTH-1:0] req0_data;
  logic [3:0]            req0_log_n;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [SIZE*WIDTH-1:0] req1_data;
  logic [3:0]            req1_log_n;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [SIZE*WIDTH-1:0] rsp_data;
  logic                  rsp_id;

  modport slave (
    input  req0_valid,
    input  req0_data,
    input  req0_log_n,
    output req0_ready,
    input  req1_valid,
    input  req1_data,
    input  req1_log_n,
    output req1_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_id,
    input  rsp_ready
  );

  modport master (
    output req0_valid,
    output req0_data,
    output req0_log_n,
    input  req0_ready,
    output req1_valid,
    output req1_data,
    output req1_log_n,
    input  req1_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id,
    output rsp_ready
  );
endinterface

// File: rtl/bit_reversal_sched.sv
// Round-robin arbiter/sequencer sharing one
// combinational bit-reversal network.
module bit_reversal_sched #(
  parameter int SIZE  = 256,
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_reversal_sched_if.slave   bus,
  output logic [SIZE*WIDTH-1:0] net_in,
  output logic [7:0]            net_perm_enable,
  input  logic [SIZE*WIDTH-1:0] net_out,
  output logic                  busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic                  last_grant;
  logic                  idle;
  logic                  pick0;
  logic                  pick1;
  logic                  rsp_valid_q;
  logic                  rsp_id_q;
  logic [SIZE*WIDTH-1:0] rsp_data_q;

  // One-hot stage select; sizes above 256 clamp to the full network
  function automatic logic [7:0] mask_of(
    input logic [3:0] l
  );
    logic [7:0] m;
    m = '0;
    if (l >= 4'd8)
      m = 8'h80;
    else if (l >= 4'd2)
      m[l[2:0] - 3'd1] = 1'b1;
    return m;
  endfunction

  always_comb begin
    idle  = (state == IDLE);
    pick1 = bus.req1_valid
          & (~bus.req0_valid | ~last_grant);
    pick0 = bus.req0_valid & ~pick1;
  end

  assign bus.req0_ready = idle & pick0;
  assign bus.req1_ready = idle & pick1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign busy           = ~idle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      last_grant      <= 1'b1;
      net_in          <= '0;
      net_perm_enable <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= 1'b0;
      rsp_data_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick0 | pick1) begin
            net_in <= pick1 ? bus.req1_data
                            : bus.req0_data;
            net_perm_enable <= mask_of(
              pick1 ? bus.req1_log_n
                    : bus.req0_log_n);
            rsp_id_q   <= pick1;
            last_grant <= pick1;
            cnt        <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            rsp_data_q  <= net_out;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_reversal_sched.sv
// Self-checking bench for bit_reversal_sched:
// directed table, corner sequences, random run.
module tb_bit_reversal_sched;

  localparam int SIZE  = 256;
  localparam int WIDTH = 32;
  localparam int VW    = SIZE * WIDTH;

  typedef logic [VW-1:0] wv_t;

  typedef struct {
    logic [3:0] log_n;
    logic [7:0] mask;
    int         i0;
    int         e0;
    int         i1;
    int         e1;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_reversal_sched_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus1 ();
  bit_reversal_sched_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus3 ();

  wv_t        net_in1, net_out1, net_in3, net_out3;
  logic [7:0] en1, en3;
  logic       busy1, busy3;

  bit_reversal_sched #(
    .SIZE(SIZE), .WIDTH(WIDTH), .LAT(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .net_in(net_in1), .net_perm_enable(en1),
    .net_out(net_out1), .busy(busy1)
  );

  bit_reversal_sched #(
    .SIZE(SIZE), .WIDTH(WIDTH), .LAT(3)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .net_in(net_in3), .net_perm_enable(en3),
    .net_out(net_out3), .busy(busy3)
  );

  function automatic int eff_len(input logic [3:0] l);
    if (l >= 4'd8) return 8;
    if (l <= 4'd1) return 0;
    return int'(l);
  endfunction

  function automatic int mask_len(input logic [7:0] m);
    int l;
    l = 0;
    for (int b = 1; b < 8; b++)
      if (m[b]) l = b + 1;
    return l;
  endfunction

  // Word i of the output is word rev_l(i) of the input
  function automatic wv_t bitrev(input wv_t v, input int l);
    wv_t o;
    o = '0;
    for (int i = 0; i < SIZE; i++) begin
      int r;
      int j;
      r = 0;
      for (int k = 0; k < l; k++)
        r = r * 2 + ((i >> k) & 1);
      j = ((i >> l) << l) + r;
      o[i*WIDTH +: WIDTH] = v[j*WIDTH +: WIDTH];
    end
    return o;
  endfunction

  function automatic wv_t ramp(input int off);
    wv_t v;
    for (int i = 0; i < SIZE; i++)
      v[i*WIDTH +: WIDTH] = WIDTH'(i + off);
    return v;
  endfunction

  always_comb net_out1 = bitrev(net_in1, mask_len(en1));

  always_comb begin
    net_out3 = bitrev(net_in3, mask_len(en3));
    net_out3[WIDTH-1:0] = WIDTH'(cyc);
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name,
                         input wv_t act,
                         input wv_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < SIZE; i++) begin
        if (act[i*WIDTH +: WIDTH] !== exp[i*WIDTH +: WIDTH]) begin
          $display("FAIL %s: word %0d got %0h expected %0h",
                   name, i, act[i*WIDTH +: WIDTH],
                   exp[i*WIDTH +: WIDTH]);
          break;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  row_t tbl[8];
  int   grants[$];
  int   ids[$];
  wv_t  exp_v;
  wv_t  d0, d1;
  int   c0;

  bit         pending;
  int         age;
  bit         m_last;
  bit         m_id;
  wv_t        m_data;
  bit         v0, v1, g0, g1, rr;
  logic [3:0] l0, l1;

  initial begin
    tbl[0] = '{4'd3,  8'h04, 1,   4,   3,   6};
    tbl[1] = '{4'd3,  8'h04, 4,   1,   8,   8};
    tbl[2] = '{4'd3,  8'h04, 255, 255, 0,   0};
    tbl[3] = '{4'd1,  8'h00, 5,   5,   200, 200};
    tbl[4] = '{4'd12, 8'h80, 1,   128, 2,   64};
    tbl[5] = '{4'd0,  8'h00, 1,   1,   2,   2};
    tbl[6] = '{4'd2,  8'h02, 1,   2,   3,   3};
    tbl[7] = '{4'd8,  8'h80, 255, 255, 127, 254};

    bus1.req0_valid = 0; bus1.req1_valid = 0;
    bus1.req0_data = '0; bus1.req1_data = '0;
    bus1.req0_log_n = '0; bus1.req1_log_n = '0;
    bus1.rsp_ready = 0;
    bus3.req0_valid = 0; bus3.req1_valid = 0;
    bus3.req0_data = '0; bus3.req1_data = '0;
    bus3.req0_log_n = '0; bus3.req1_log_n = '0;
    bus3.rsp_ready = 0;

    @(negedge clk);
    step();
    step();
    chk("rst_rsp_valid", bus1.rsp_valid, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_mask", en1, 0);
    chk("rst_rsp_id", bus1.rsp_id, 0);
    chk_vec("rst_rsp_data", bus1.rsp_data, '0);
    chk_vec("rst_net_in", net_in1, '0);
    rst_n = 1;

    foreach (tbl[t]) begin
      bus1.req0_data  = ramp(0);
      bus1.req0_log_n = tbl[t].log_n;
      bus1.req0_valid = 1;
      bus1.rsp_ready  = 0;
      #1;
      chk("tbl_ready0", bus1.req0_ready, 1);
      chk("tbl_ready1", bus1.req1_ready, 0);
      step();
      bus1.req0_valid = 0;
      chk("tbl_mask", en1, tbl[t].mask);
      chk("tbl_settle_valid", bus1.rsp_valid, 0);
      chk("tbl_settle_busy", busy1, 1);
      step();
      chk("tbl_rsp_valid", bus1.rsp_valid, 1);
      chk("tbl_rsp_id", bus1.rsp_id, 0);
      chk("tbl_word_a",
          bus1.rsp_data[tbl[t].i0*WIDTH +: WIDTH], tbl[t].e0);
      chk("tbl_word_b",
          bus1.rsp_data[tbl[t].i1*WIDTH +: WIDTH], tbl[t].e1);
      chk_vec("tbl_vec", bus1.rsp_data,
              bitrev(ramp(0), eff_len(tbl[t].log_n)));
      bus1.rsp_ready = 1;
      step();
      chk("tbl_rsp_drop", bus1.rsp_valid, 0);
      chk("tbl_idle", busy1, 0);
      bus1.rsp_ready = 0;
    end

    rst_n = 0;
    step();
    rst_n = 1;
    bus1.req0_data = ramp(0);
    bus1.req1_data = ramp(1000);
    bus1.req0_log_n = 4'd4;
    bus1.req1_log_n = 4'd5;
    bus1.req0_valid = 1;
    bus1.req1_valid = 1;
    bus1.rsp_ready = 1;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("cont_ready_busy",
          (bus1.req0_ready | bus1.req1_ready) & busy1, 0);
      if (bus1.req0_ready | bus1.req1_ready)
        grants.push_back(int'(bus1.req1_ready));
      if (bus1.rsp_valid) begin
        ids.push_back(int'(bus1.rsp_id));
        chk_vec("cont_data", bus1.rsp_data,
                bus1.rsp_id ? bitrev(ramp(1000), 5)
                            : bitrev(ramp(0), 4));
      end
      step();
    end
    bus1.req0_valid = 0;
    bus1.req1_valid = 0;
    chk("cont_grant_count", grants.size() >= 4, 1);
    chk("cont_rsp_count", ids.size() >= 4, 1);
    for (int k = 0; k < grants.size(); k++)
      chk("cont_grant_order", grants[k], k % 2);
    for (int k = 0; k < ids.size(); k++)
      chk("cont_rsp_order", ids[k], k % 2);
    step(); step(); step();
    chk("cont_drained", busy1, 0);

    bus1.rsp_ready = 0;
    bus1.req0_data = ramp(7);
    bus1.req0_log_n = 4'd6;
    bus1.req0_valid = 1;
    #1;
    chk("bp_ready0", bus1.req0_ready, 1);
    step();
    bus1.req0_data = ramp(9);
    bus1.req1_data = ramp(11);
    bus1.req1_log_n = 4'd2;
    bus1.req1_valid = 1;
    step();
    exp_v = bitrev(ramp(7), 6);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", bus1.rsp_valid, 1);
      chk("bp_id", bus1.rsp_id, 0);
      chk_vec("bp_data", bus1.rsp_data, exp_v);
      chk("bp_ready0_low", bus1.req0_ready, 0);
      chk("bp_ready1_low", bus1.req1_ready, 0);
      step();
    end
    bus1.rsp_ready = 1;
    #1;
    chk("bp_no_turnaround",
        bus1.req0_ready | bus1.req1_ready, 0);
    step();
    chk("bp_idle", busy1, 0);
    chk("bp_rsp_drop", bus1.rsp_valid, 0);
    #1;
    chk("bp_next_grant1", bus1.req1_ready, 1);
    step();
    bus1.req0_valid = 0;
    bus1.req1_valid = 0;
    chk("bp_next_busy", busy1, 1);
    step();
    chk("bp_next_id", bus1.rsp_id, 1);
    chk_vec("bp_next_data", bus1.rsp_data,
            bitrev(ramp(11), 2));
    step(); step();

    bus1.rsp_ready = 0;
    bus1.req0_data = ramp(3);
    bus1.req0_log_n = 4'd5;
    bus1.req0_valid = 1;
    step();
    bus1.req0_valid = 0;
    chk("mid_settle_busy", busy1, 1);
    rst_n = 0;
    step();
    chk("mid_rsp_valid", bus1.rsp_valid, 0);
    chk("mid_busy", busy1, 0);
    chk("mid_mask", en1, 0);
    bus1.req0_valid = 1;
    bus1.req1_valid = 1;
    step();
    chk("mid_rsp_valid2", bus1.rsp_valid, 0);
    rst_n = 1;
    #1;
    chk("mid_first_ready0", bus1.req0_ready, 1);
    chk("mid_first_ready1", bus1.req1_ready, 0);
    step();
    bus1.req0_valid = 0;
    bus1.req1_valid = 0;
    step();
    chk("mid_first_id", bus1.rsp_id, 0);
    chk("mid_first_valid", bus1.rsp_valid, 1);
    bus1.rsp_ready = 1;
    step();
    bus1.rsp_ready = 0;

    bus3.req1_data = ramp(50);
    bus3.req1_log_n = 4'd8;
    bus3.req1_valid = 1;
    #1;
    chk("l3_ready1", bus3.req1_ready, 1);
    c0 = cyc;
    step();
    bus3.req1_valid = 0;
    for (int e = 0; e < 3; e++) begin
      chk("l3_early_valid", bus3.rsp_valid, 0);
      chk("l3_busy", busy3, 1);
      step();
    end
    chk("l3_valid", bus3.rsp_valid, 1);
    chk("l3_id", bus3.rsp_id, 1);
    chk("l3_word0_edge", bus3.rsp_data[WIDTH-1:0], c0 + 3);
    exp_v = bitrev(ramp(50), 8);
    exp_v[WIDTH-1:0] = WIDTH'(c0 + 3);
    chk_vec("l3_data", bus3.rsp_data, exp_v);
    bus3.rsp_ready = 1;
    step();
    chk("l3_drop", bus3.rsp_valid, 0);

    rst_n = 0;
    step();
    rst_n = 1;
    pending = 0;
    age = 0;
    m_last = 1;
    m_id = 0;
    m_data = '0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_busy", busy1, pending);
      chk("rnd_valid", bus1.rsp_valid, pending && age >= 1);
      if (pending && age >= 1) begin
        chk("rnd_id", bus1.rsp_id, m_id);
        chk_vec("rnd_data", bus1.rsp_data, m_data);
      end
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 6);
      rr = ($urandom_range(0, 9) < 5);
      l0 = 4'($urandom_range(0, 15));
      l1 = 4'($urandom_range(0, 15));
      for (int w = 0; w < SIZE; w++) begin
        d0[w*WIDTH +: WIDTH] = $urandom;
        d1[w*WIDTH +: WIDTH] = $urandom;
      end
      bus1.req0_valid = v0;
      bus1.req1_valid = v1;
      bus1.req0_data = d0;
      bus1.req1_data = d1;
      bus1.req0_log_n = l0;
      bus1.req1_log_n = l1;
      bus1.rsp_ready = rr;
      #1;
      g0 = !pending && v0 && (!v1 || m_last);
      g1 = !pending && v1 && !(v0 && (!v1 || m_last));
      chk("rnd_ready0", bus1.req0_ready, g0);
      chk("rnd_ready1", bus1.req1_ready, g1);
      if (pending && age >= 1 && rr) begin
        pending = 0;
      end else if (pending) begin
        age++;
      end else if (g0 || g1) begin
        pending = 1;
        age = 0;
        m_last = g1;
        m_id = g1;
        m_data = g1 ? bitrev(d1, eff_len(l1))
                    : bitrev(d0, eff_len(l0));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
